// File: rtl/add8u_char_seq.sv
// On-chip characteriser for one approximate W-bit adder: sweeps every (a, b) pair, accumulates error statistics.
// Latency 1 + 2^(2W) + LAT cycles from accepted start to done; no backpressure, start is ignored unless idle.
module add8u_char_seq #(
   parameter int W   = 8,
   parameter int LAT = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   dut_a,
   output logic [W-1:0]   dut_b,
   input  logic [W:0]     dut_o,
   output logic [3*W:0]   sum_abs_err,
   output logic [W:0]     wce,
   output logic [W-1:0]   wce_a,
   output logic [W-1:0]   wce_b,
   output logic [2*W:0]   err_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t       state;
   logic [1:0]   drain_cnt;
   logic         last_pair;
   logic         issue_vld;
   logic [W:0]   issue_ref;

   logic         cmp_vld;
   logic [W:0]   cmp_ref;
   logic [W-1:0] cmp_a;
   logic [W-1:0] cmp_b;
   logic [W:0]   err_mag;

   assign issue_vld = (state == RUN);
   assign issue_ref = {1'b0, dut_a} + {1'b0, dut_b};
   assign last_pair = issue_vld && (&dut_a) && (&dut_b);

   // Reference sum and operands travel alongside the adder's own pipeline so the compare lines up.
   generate
      if (LAT == 0) begin : g_comb
         assign cmp_vld = issue_vld;
         assign cmp_ref = issue_ref;
         assign cmp_a   = dut_a;
         assign cmp_b   = dut_b;
      end else begin : g_pipe
         logic [LAT-1:0] vld_q;
         logic [W:0]     ref_q [LAT];
         logic [W-1:0]   a_q   [LAT];
         logic [W-1:0]   b_q   [LAT];

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= issue_vld;
               for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            ref_q[0] <= issue_ref;
            a_q[0]   <= dut_a;
            b_q[0]   <= dut_b;
            for (int i = 1; i < LAT; i++) begin
               ref_q[i] <= ref_q[i-1];
               a_q[i]   <= a_q[i-1];
               b_q[i]   <= b_q[i-1];
            end
         end

         assign cmp_vld = vld_q[LAT-1];
         assign cmp_ref = ref_q[LAT-1];
         assign cmp_a   = a_q[LAT-1];
         assign cmp_b   = b_q[LAT-1];
      end
   endgenerate

   assign err_mag = (dut_o >= cmp_ref) ? (dut_o - cmp_ref) : (cmp_ref - dut_o);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         drain_cnt   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         dut_a       <= '0;
         dut_b       <= '0;
         sum_abs_err <= '0;
         wce         <= '0;
         wce_a       <= '0;
         wce_b       <= '0;
         err_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state       <= RUN;
                  busy        <= 1'b1;
                  dut_a       <= '0;
                  dut_b       <= '0;
                  sum_abs_err <= '0;
                  wce         <= '0;
                  wce_a       <= '0;
                  wce_b       <= '0;
                  err_cnt     <= '0;
               end
            end
            RUN: begin
               if (last_pair) begin
                  drain_cnt <= '0;
                  if (LAT > 0) begin
                     state <= DRAIN;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  dut_a <= dut_a + W'(1);
                  if (&dut_a) dut_b <= dut_b + W'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt == 2'(LAT - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 2'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         // Strict compare keeps the earliest pair in sweep order on ties.
         if (cmp_vld) begin
            sum_abs_err <= sum_abs_err + (3*W+1)'(err_mag);
            err_cnt     <= err_cnt + (2*W+1)'(err_mag != '0);
            if (err_mag > wce) begin
               wce   <= err_mag;
               wce_a <= cmp_a;
               wce_b <= cmp_b;
            end
         end
      end
   end

endmodule

// File: tb/tb_add8u_char_seq.sv
// Bench for add8u_char_seq: two instances (LAT=0 and LAT=2, W=4) against a family of adder models.
module tb_add8u_char_seq;
   localparam int W  = 4;
   localparam int N  = 1 << W;
   localparam int NP = N * N;

   logic clk = 1'b0;
   logic rst;
   logic start;
   always #5 clk = ~clk;

   logic           busy0, done0, busy2, done2;
   logic [W-1:0]   a0, b0, a2, b2;
   logic [W:0]     o0, o2;
   logic [3*W:0]   sae0, sae2;
   logic [W:0]     wce0, wce2;
   logic [W-1:0]   wa0, wb0, wa2, wb2;
   logic [2*W:0]   cnt0, cnt2;

   int mode = 0;
   int dly  = 2;
   int lut [NP];
   int cyc  = 0;
   int checks = 0;
   int errors = 0;
   int seen0 = 0;
   int seen2 = 0;

   typedef struct {
      longint sae;
      int     wce;
      int     wa;
      int     wb;
      int     cnt;
      int     dcyc;
   } exp_t;

   exp_t q0[$];
   exp_t q2[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Adder-under-test models: exact, stuck-zero, off-by-one, lower-part-OR, random table.
   function automatic int f(int m, int a, int b);
      case (m)
         0:       return a + b;
         1:       return 0;
         2:       return a + b + 1;
         3:       return (((a >> 2) + (b >> 2)) << 2) | ((a | b) & 3);
         default: return lut[b*N + a];
      endcase
   endfunction

   logic [W-1:0] a2_d1, b2_d1, a2_d2, b2_d2;
   always @(posedge clk) begin
      a2_d1 <= a2;
      b2_d1 <= b2;
      a2_d2 <= a2_d1;
      b2_d2 <= b2_d1;
   end

   assign o0 = (W+1)'(f(mode, int'(a0), int'(b0)));
   assign o2 = (dly == 2) ? (W+1)'(f(mode, int'(a2_d2), int'(b2_d2)))
                          : (W+1)'(f(mode, int'(a2_d1), int'(b2_d1)));

   add8u_char_seq #(.W(W), .LAT(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
      .dut_a(a0), .dut_b(b0), .dut_o(o0), .sum_abs_err(sae0), .wce(wce0),
      .wce_a(wa0), .wce_b(wb0), .err_cnt(cnt0)
   );

   add8u_char_seq #(.W(W), .LAT(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2),
      .dut_a(a2), .dut_b(b2), .dut_o(o2), .sum_abs_err(sae2), .wce(wce2),
      .wce_a(wa2), .wce_b(wb2), .err_cnt(cnt2)
   );

   // Pair k (a inner) is compared against the model's output for pair k+shift, clamped at the final pair.
   function automatic exp_t model(int m, int shift);
      exp_t r;
      r = '{default: 0};
      for (int k = 0; k < NP; k++) begin
         int a, b, j, e;
         a = k % N;
         b = k / N;
         j = (k + shift < NP) ? k + shift : NP - 1;
         e = f(m, j % N, j / N) - (a + b);
         if (e < 0) e = -e;
         r.sae += e;
         if (e != 0) r.cnt++;
         if (e > r.wce) begin
            r.wce = e;
            r.wa  = a;
            r.wb  = b;
         end
      end
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_result(string nm, exp_t e, logic [3*W:0] sae, logic [W:0] wce,
                               logic [W-1:0] wa, logic [W-1:0] wb, logic [2*W:0] cnt, logic bsy);
      chk({nm, " sum_abs_err"}, 64'(sae), 64'(e.sae));
      chk({nm, " wce"},         64'(wce), 64'(e.wce));
      chk({nm, " wce_a"},       64'(wa),  64'(e.wa));
      chk({nm, " wce_b"},       64'(wb),  64'(e.wb));
      chk({nm, " err_cnt"},     64'(cnt), 64'(e.cnt));
      chk({nm, " done_cycle"},  64'(cyc), 64'(e.dcyc));
      chk({nm, " busy_at_done"}, 64'(bsy), 64'(0));
   endtask

   always @(negedge clk) begin
      if (done0 === 1'b1) begin
         seen0++;
         if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut0 done: pulse at cycle %0d, expected none pending", cyc);
         end else begin
            check_result("dut0", q0.pop_front(), sae0, wce0, wa0, wb0, cnt0, busy0);
         end
      end
   end

   always @(negedge clk) begin
      if (done2 === 1'b1) begin
         seen2++;
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut2 done: pulse at cycle %0d, expected none pending", cyc);
         end else begin
            check_result("dut2", q2.pop_front(), sae2, wce2, wa2, wb2, cnt2, busy2);
         end
      end
   end

   task automatic check_zero(string nm);
      chk({nm, " busy0"}, 64'(busy0), 0);  chk({nm, " busy2"}, 64'(busy2), 0);
      chk({nm, " done0"}, 64'(done0), 0);  chk({nm, " done2"}, 64'(done2), 0);
      chk({nm, " a0"},    64'(a0), 0);     chk({nm, " b0"},    64'(b0), 0);
      chk({nm, " a2"},    64'(a2), 0);     chk({nm, " b2"},    64'(b2), 0);
      chk({nm, " sae0"},  64'(sae0), 0);   chk({nm, " sae2"},  64'(sae2), 0);
      chk({nm, " wce0"},  64'(wce0), 0);   chk({nm, " wce2"},  64'(wce2), 0);
      chk({nm, " wa0"},   64'(wa0), 0);    chk({nm, " wb0"},   64'(wb0), 0);
      chk({nm, " wa2"},   64'(wa2), 0);    chk({nm, " wb2"},   64'(wb2), 0);
      chk({nm, " cnt0"},  64'(cnt0), 0);   chk({nm, " cnt2"},  64'(cnt2), 0);
   endtask

   // poke: 0 none, 1 start pulse mid-RUN, 2 start held from mid-RUN through dut0's DONE cycle.
   task automatic run(int m, int d, int poke);
      exp_t e;
      int t0, t2, n;
      bit poke_live;
      mode = m;
      dly  = d;
      if (m == 4) for (int i = 0; i < NP; i++) lut[i] = $urandom_range(0, 2*N - 1);
      repeat ($urandom_range(1, 5)) @(negedge clk);
      t0 = seen0 + 1;
      t2 = seen2 + 1;
      e = model(m, 0);
      e.dcyc = cyc + 1 + NP;
      q0.push_back(e);
      e = model(m, 2 - d);
      e.dcyc = cyc + 1 + NP + 2;
      q2.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy0 after start", 64'(busy0), 1);
      chk("busy2 after start", 64'(busy2), 1);
      poke_live = 1'b0;
      n = 0;
      while ((seen0 < t0 || seen2 < t2) && n < NP + 50) begin
         @(negedge clk);
         n++;
         if (poke != 0 && n == 60) begin
            start = 1'b1;
            poke_live = (poke == 2);
            if (poke == 1) begin
               @(negedge clk);
               n++;
               start = 1'b0;
            end
         end else if (poke_live && done0 === 1'b1) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            poke_live = 1'b0;
         end
      end
      start = 1'b0;
      if (seen0 < t0 || seen2 < t2) begin
         checks++;
         errors++;
         $display("FAIL done timeout: mode %0d seen0 %0d seen2 %0d, expected %0d %0d", m, seen0, seen2, t0, t2);
         q0.delete();
         q2.delete();
      end
      repeat (3) @(negedge clk);
      chk("busy0 idle after done", 64'(busy0), 0);
      chk("busy2 idle after done", 64'(busy2), 0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      run(0, 2, 0);
      run(1, 2, 0);
      run(2, 2, 0);
      run(3, 2, 0);
      run(4, 2, 0);
      run(4, 2, 0);
      run(0, 1, 0);
      run(4, 2, 1);
      run(3, 2, 2);

      // Abort mid-sweep: no result may surface afterwards.
      @(negedge clk);
      mode  = 1;
      dly   = 2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero("midreset");
      rst = 1'b0;
      repeat (NP + 10) @(negedge clk);
      chk("busy0 stays idle after abort", 64'(busy0), 0);

      run(4, 2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
